// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - MIPS-style writeback register file with GPRs, HI/LO and optional retire counter
//
// Purpose:
//   Holds 32 x 32-bit general purpose registers plus the HI/LO pair.
//   Writes land on the rising clock edge. Reads are combinational and
//   forward the value being written back in the same cycle.
//   Optional feature macro: WB_RETIRE_CNT_EN adds a free-running
//   32-bit writeback event counter on port retire_cnt.
//
// Ports:
//   clk                      system clock, rising edge
//   rst                      synchronous reset, active-high
//   wb_wreg, wb_wd, wb_wdata GPR write enable / address / data
//   wb_whilo, wb_hi, wb_lo   HI/LO write enable / data
//   re1, raddr1, rdata1      read port 1 enable / address / data
//   re2, raddr2, rdata2      read port 2 enable / address / data
//   hi_o, lo_o               current HI/LO, with same-cycle forwarding
//   retire_cnt               writeback event count (WB_RETIRE_CNT_EN only)

module wb_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_wreg,
  input  logic [4:0]  wb_wd,
  input  logic [31:0] wb_wdata,
  input  logic        wb_whilo,
  input  logic [31:0] wb_hi,
  input  logic [31:0] wb_lo,
  input  logic        re1,
  input  logic [4:0]  raddr1,
  input  logic        re2,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0] retire_cnt
`endif
);

  logic [31:0] gpr [0:31];
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  // GPR storage; entry 0 is only ever cleared by reset so it stays zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        gpr[i] <= 32'h0000_0000;
      end
    end else if (wb_wreg && (wb_wd != 5'd0)) begin
      gpr[wb_wd] <= wb_wdata;
    end
  end

  // HI and LO always update as a pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= 32'h0000_0000;
      lo_q <= 32'h0000_0000;
    end else if (wb_whilo) begin
      hi_q <= wb_hi;
      lo_q <= wb_lo;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  // One count per retiring cycle, even when the GPR write targets $0.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt <= 32'h0000_0000;
    end else if (wb_wreg || wb_whilo) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end
`endif

  // Address 0 wins over forwarding so $0 always reads as zero.
  function automatic logic [31:0] read_port(input logic re, input logic [4:0] raddr);
    logic [31:0] val;
    val = 32'h0000_0000;
    if (re && (raddr != 5'd0)) begin
      if (wb_wreg && (raddr == wb_wd)) begin
        val = wb_wdata;
      end else begin
        val = gpr[raddr];
      end
    end
    return val;
  endfunction

  always_comb begin
    rdata1 = read_port(re1, raddr1);
    rdata2 = read_port(re2, raddr2);
  end

  // Forwarding stays live during reset; only the stored copies clear.
  always_comb begin
    hi_o = wb_whilo ? wb_hi : hi_q;
    lo_o = wb_whilo ? wb_lo : lo_q;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - self-checking bench for wb_regfile with a reference model

module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        wb_wreg;
  logic [4:0]  wb_wd;
  logic [31:0] wb_wdata;
  logic        wb_whilo;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic        re1;
  logic [4:0]  raddr1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  int checks;
  int failures;

  // Reference state
  logic [31:0] m_gpr [32];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [31:0] m_cnt;

  wb_regfile dut (
    .clk      (clk),
    .rst      (rst),
    .wb_wreg  (wb_wreg),
    .wb_wd    (wb_wd),
    .wb_wdata (wb_wdata),
    .wb_whilo (wb_whilo),
    .wb_hi    (wb_hi),
    .wb_lo    (wb_lo),
    .re1      (re1),
    .raddr1   (raddr1),
    .re2      (re2),
    .raddr2   (raddr2),
    .rdata1   (rdata1),
    .rdata2   (rdata2),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt (retire_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected read value from the architectural rules.
  function automatic logic [31:0] exp_read(input logic re, input logic [4:0] a);
    if (!re || a == 5'd0) return 32'h0;
    if (wb_wreg && a == wb_wd) return wb_wdata;
    return m_gpr[a];
  endfunction

  task automatic idle();
    rst = 1'b0; wb_wreg = 1'b0; wb_wd = 5'd0; wb_wdata = 32'h0;
    wb_whilo = 1'b0; wb_hi = 32'h0; wb_lo = 32'h0;
    re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;
  endtask

  // Check combinational outputs against the model, clock once, advance the model.
  task automatic step(input string tag);
    #1;
    chk({tag, ".rdata1"}, rdata1, exp_read(re1, raddr1));
    chk({tag, ".rdata2"}, rdata2, exp_read(re2, raddr2));
    chk({tag, ".hi_o"}, hi_o, wb_whilo ? wb_hi : m_hi);
    chk({tag, ".lo_o"}, lo_o, wb_whilo ? wb_lo : m_lo);
`ifdef WB_RETIRE_CNT_EN
    chk({tag, ".retire_cnt"}, retire_cnt, m_cnt);
`endif
    @(posedge clk);
    if (rst) begin
      foreach (m_gpr[i]) m_gpr[i] = 32'h0;
      m_hi = 32'h0; m_lo = 32'h0; m_cnt = 32'h0;
    end else begin
      if (wb_wreg && wb_wd != 5'd0) m_gpr[wb_wd] = wb_wdata;
      if (wb_whilo) begin m_hi = wb_hi; m_lo = wb_lo; end
      if (wb_wreg || wb_whilo) m_cnt = m_cnt + 32'd1;
    end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    foreach (m_gpr[i]) m_gpr[i] = 32'h0;
    m_hi = 32'h0; m_lo = 32'h0; m_cnt = 32'h0;

    idle();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // Reset state
    idle();
    re1 = 1'b1; raddr1 = 5'd5;
    #1;
    chk("rst_rdata1", rdata1, 32'h0);
    chk("rst_hi", hi_o, 32'h0);
    chk("rst_lo", lo_o, 32'h0);
    step("rst_read");

    // Same-cycle forwarding to both ports, then stored value
    idle();
    wb_wreg = 1'b1; wb_wd = 5'd5; wb_wdata = 32'hDEAD_BEEF;
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
    #1;
    chk("fwd_rdata1", rdata1, 32'hDEAD_BEEF);
    chk("fwd_rdata2", rdata2, 32'hDEAD_BEEF);
    step("fwd");
    wb_wreg = 1'b0; wb_wdata = 32'h0;
    #1;
    chk("held_rdata1", rdata1, 32'hDEAD_BEEF);
    chk("held_rdata2", rdata2, 32'hDEAD_BEEF);
    step("held");

    // Disabled read port returns zero
    idle();
    re1 = 1'b0; raddr1 = 5'd5;
    #1;
    chk("re0_rdata1", rdata1, 32'h0);
    step("re0");

    // Write to $0 discarded, still counts
    idle();
    wb_wreg = 1'b1; wb_wd = 5'd0; wb_wdata = 32'h1234_5678;
    re1 = 1'b1; raddr1 = 5'd0;
    #1;
    chk("r0_same", rdata1, 32'h0);
    step("r0_wr");
    wb_wreg = 1'b0;
    #1;
    chk("r0_next", rdata1, 32'h0);
    step("r0_rd");

    // GPR and HI/LO write together
    idle();
    wb_whilo = 1'b1; wb_hi = 32'hAAAA_0000; wb_lo = 32'h0000_BBBB;
    wb_wreg = 1'b1; wb_wd = 5'd3; wb_wdata = 32'd7;
    #1;
    chk("hilo_fwd_hi", hi_o, 32'hAAAA_0000);
    chk("hilo_fwd_lo", lo_o, 32'h0000_BBBB);
    step("hilo_wr");
    idle();
    re1 = 1'b1; raddr1 = 5'd3;
    #1;
    chk("hilo_gpr3", rdata1, 32'd7);
    chk("hilo_held_hi", hi_o, 32'hAAAA_0000);
    chk("hilo_held_lo", lo_o, 32'h0000_BBBB);
    step("hilo_rd");

    // Write in a reset cycle is discarded; forwarding still visible
    idle();
    rst = 1'b1; wb_wreg = 1'b1; wb_wd = 5'd9; wb_wdata = 32'h55;
    re1 = 1'b1; raddr1 = 5'd9;
    #1;
    chk("rstwr_fwd", rdata1, 32'h55);
    step("rstwr");
    idle();
    re1 = 1'b1; raddr1 = 5'd9; re2 = 1'b1; raddr2 = 5'd3;
    #1;
    chk("rstwr_gpr9", rdata1, 32'h0);
    chk("rstwr_gpr3", rdata2, 32'h0);
    chk("rstwr_hi", hi_o, 32'h0);
    step("rstwr_rd");

    // First write after reset lands normally
    idle();
    wb_wreg = 1'b1; wb_wd = 5'd9; wb_wdata = 32'hCAFE_0009;
    step("post_rst_wr");
    idle();
    re2 = 1'b1; raddr2 = 5'd9;
    #1;
    chk("post_rst_gpr9", rdata2, 32'hCAFE_0009);
    step("post_rst_rd");

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 39) == 0);
      wb_wreg  = $urandom_range(0, 1);
      wb_wd    = 5'($urandom);
      wb_wdata = $urandom;
      wb_whilo = ($urandom_range(0, 3) == 0);
      wb_hi    = $urandom;
      wb_lo    = $urandom;
      re1      = ($urandom_range(0, 7) != 0);
      re2      = ($urandom_range(0, 7) != 0);
      raddr1   = ($urandom_range(0, 3) == 0) ? wb_wd : 5'($urandom);
      raddr2   = ($urandom_range(0, 3) == 0) ? wb_wd : 5'($urandom);
      step("rand");
    end

`ifdef WB_RETIRE_CNT_EN
    // Counter wrap from a forced preload
    idle();
    force dut.retire_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.retire_cnt;
    m_cnt = 32'hFFFF_FFFE;
    wb_wreg = 1'b1; wb_wd = 5'd1; wb_wdata = 32'h1;
    step("wrap1");
    #1;
    chk("wrap_ffffffff", retire_cnt, 32'hFFFF_FFFF);
    step("wrap2");
    idle();
    #1;
    chk("wrap_zero", retire_cnt, 32'h0);
    step("wrap3");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 One clock; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous reset, active-high (RstEnable).
REQ-004 wb_wreg  input  1  GPR write enable from MEM/WB register.
REQ-005 wb_wd  input  5  GPR write address.
REQ-006 wb_wdata  input  32  GPR write data.
REQ-007 wb_whilo  input  1  HI/LO write enable.
REQ-008 wb_hi  input  32  HI write data.
REQ-009 wb_lo  input  32  LO write data.
REQ-010 re1 / re2  input  1 each  read-port enables.
REQ-011 raddr1 / raddr2  input  5 each  read addresses.
REQ-012 rdata1 / rdata2  output  32 each  read data, combinational.
REQ-013 hi_o / lo_o  output  32 each  current HI/LO values, combinational.
REQ-014 retire_cnt  output  32  writeback event count; present only with WB_RETIRE_CNT_EN.

Function
REQ-015 GPR storage: 32 x 32-bit, written on rising clk when wb_wreg=1, wb_wd!=0, rst=0.
REQ-016 Register $0: writes discarded; reads of address 0 return 0x00000000 regardless of bypass.
REQ-017 Read port n, re=0: rdata=0x00000000.
REQ-018 Read port n, re=1, raddr==wb_wd, wb_wreg=1, raddr!=0: rdata=wb_wdata (same-cycle write-through bypass).
REQ-019 Otherwise re=1: rdata=stored GPR[raddr].
REQ-020 Both ports may address the same register, including the one being written; each resolves independently per REQ-016..019.
REQ-021 HI/LO: both registers written together on rising clk when wb_whilo=1, rst=0; no partial write.
REQ-022 hi_o/lo_o bypass: wb_whilo=1 -> hi_o=wb_hi, lo_o=wb_lo; else stored values.
REQ-023 GPR write and HI/LO write in the same cycle: both take effect; independent paths.
REQ-024 Write latency: 1 cycle to storage; 0 cycles to read ports via bypass.
REQ-025 Read path: purely combinational from inputs and stored state; no read-side registers.

Reset
REQ-026 rst=1 at rising clk: all 32 GPRs, HI, LO <= 0x00000000; retire_cnt <= 0 (if present).
REQ-027 Writes presented in a reset cycle are discarded; no GPR/HI/LO/counter update.
REQ-028 Bypass paths stay active during rst=1 (combinational); stored values read as zero after the reset edge.
REQ-029 Reset asserted mid-sequence clears state on that edge; first write after rst deasserts lands normally.

Configuration
REQ-030 Macro WB_RETIRE_CNT_EN: defined -> retire_cnt port and 32-bit counter present; undefined -> port and counter absent, all other behaviour identical.
REQ-031 Counter increments by 1 per rising clk with rst=0 and (wb_wreg=1 or wb_whilo=1); a cycle with both increments by 1 only.
REQ-032 wb_wreg=1 with wb_wd=0 still counts (instruction retired, write discarded).
REQ-033 Counter wraps 0xFFFFFFFF -> 0x00000000, no saturation, no flag.

Verification
REQ-034 Reset, then re1=1 raddr1=5 -> rdata1=0x00000000; hi_o=lo_o=0x00000000.
REQ-035 Cycle N: wb_wreg=1 wb_wd=5 wb_wdata=0xDEADBEEF, re1=re2=1 raddr1=raddr2=5 -> both rdata=0xDEADBEEF same cycle; cycle N+1 with wb_wreg=0 -> still 0xDEADBEEF.
REQ-036 wb_wreg=1 wb_wd=0 wb_wdata=0x12345678 -> rdata for raddr=0 stays 0x00000000 same and next cycle; retire_cnt +1.
REQ-037 wb_whilo=1 wb_hi=0xAAAA0000 wb_lo=0x0000BBBB with wb_wreg=1 wb_wd=3 wb_wdata=7 -> same cycle hi_o/lo_o bypassed; next cycle GPR3=7, HI/LO held; retire_cnt +1 only.
REQ-038 Write GPR9=0x55 with rst=1 on that edge -> GPR9 reads 0x00000000 after deassert.
REQ-039 With WB_RETIRE_CNT_EN: preload 0xFFFFFFFE via two-step sequence from forced state or 2^32-2 writes (force permitted), two writes -> 0xFFFFFFFF then 0x00000000.
